mbox_arb: RTL and testbench
===========================

MBOX_ARB -- requirements
Module: mbox_arb

Interface
REQ-001 Parameter WIDTH, default 8: data width per channel, >=1.
REQ-002 Parameter NCH, default 4: number of write channels, >=2.
REQ-003 Parameter DEPTH, default 4: FIFO entries per channel, power of two, >=2.
REQ-004 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 wr_valid  input  NCH  per-channel write request.
REQ-008 wr_data  input  NCH*WIDTH  per-channel write data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 wr_ready  output  NCH  per-channel not-full indication.
REQ-010 rd_valid  output  1  at least one channel holds data.
REQ-011 rd_ready  input  1  consumer accepts rd_data.
REQ-012 rd_data  output  WIDTH  head entry of the granted channel.
REQ-013 rd_chan  output  $clog2(NCH)  index of the granted channel.
REQ-014 level  output  NCH*($clog2(DEPTH)+1)  per-channel occupancy count.
REQ-015 drop_cnt  output  8  count of rejected writes, saturating.

Function
REQ-016 Each channel SHALL own an independent DEPTH-entry FIFO with wrapping read and write pointers.
REQ-017 wr_ready[i] SHALL be 1 exactly when level[i] < DEPTH, derived only from registered state.
REQ-018 A push to channel i SHALL occur on a clock edge where wr_valid[i] && wr_ready[i].
REQ-019 On a full channel, a push SHALL NOT occur even if the same channel pops in that cycle.
REQ-020 rd_valid SHALL be 1 exactly when any level[i] != 0.
REQ-021 A pop SHALL occur on a clock edge where rd_valid && rd_ready; it removes the head of channel rd_chan.
REQ-022 Push and pop on the same channel in one cycle SHALL leave level unchanged and move both pointers.
REQ-023 Arbitration SHALL be round-robin: the search starts at (last_grant+1) mod NCH and picks the first non-empty channel.
REQ-024 last_grant SHALL update to rd_chan only on a pop.
REQ-025 While rd_valid && !rd_ready, rd_chan and rd_data SHALL hold stable: the grant is locked until the pop.
REQ-026 When rd_valid is 0, rd_chan SHALL be 0 and rd_data SHALL be 0.
REQ-027 Latency: data pushed at edge k SHALL be visible on rd_data, with rd_valid=1, after edge k; there is no same-cycle bypass.
REQ-028 drop_cnt SHALL increment by the number of channels with wr_valid && !wr_ready at each edge, and SHALL saturate at 255.
REQ-029 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.

Reset
REQ-030 On rst_n low, asynchronously: all levels and pointers 0, last_grant = NCH-1, grant lock cleared, drop_cnt 0.
REQ-031 During reset, outputs SHALL be: rd_valid 0, rd_data 0, rd_chan 0, wr_ready all 1.
REQ-032 Reset asserted mid-transfer SHALL discard all stored data; FIFO contents need no clearing.
REQ-033 The first post-reset grant SHALL search from channel 0.

Verification
REQ-034 After reset, push 8'hAB on channel 2 -> next cycle rd_valid=1, rd_chan=2, rd_data=AB, level[2]=1; pop -> rd_valid=0.
REQ-035 Channels 0,1,3 each hold one entry, rd_ready held 1 -> pops in order 0,1,3, then rd_valid=0.
REQ-036 Fill channel 0 with 4 entries, then drive a 5th write -> wr_ready[0]=0, data unchanged, drop_cnt=1; 300 rejected writes -> drop_cnt=255.
REQ-037 Channel 1 granted with rd_ready=0; push to channel 0 -> rd_chan stays 1 and rd_data is stable until the pop.
REQ-038 Push 8'h11 and pop on a channel with level 2 in the same cycle -> level stays 2 and FIFO order is preserved across the pointer wrap.
REQ-039 Assert rst_n low while 3 channels hold data -> immediately rd_valid=0, all levels 0; after release, a push to channel 3 is granted normally.

Source files
------------

// File: rtl/mbox_arb.sv
// Multi-channel mailbox: one FIFO per write channel, drained by a single
// round-robin reader whose grant stays locked while a read is pending.
module mbox_arb #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NCH-1:0]                     wr_valid,
   input  logic [NCH*WIDTH-1:0]               wr_data,
   output logic [NCH-1:0]                     wr_ready,
   output logic                               rd_valid,
   input  logic                               rd_ready,
   output logic [WIDTH-1:0]                   rd_data,
   output logic [$clog2(NCH)-1:0]             rd_chan,
   output logic [NCH*($clog2(DEPTH)+1)-1:0]   level,
   output logic [7:0]                         drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(NCH);

   logic [WIDTH-1:0] mem_q [NCH][DEPTH];
   logic [AW-1:0]    wr_ptr_q [NCH];
   logic [AW-1:0]    rd_ptr_q [NCH];
   logic [LW-1:0]    level_q  [NCH];
   logic [CW-1:0]    last_grant_q;
   logic [CW-1:0]    lock_chan_q;
   logic             lock_q;
   logic [7:0]       drop_cnt_q;
   logic [7:0]       drop_cnt_d;

   logic [NCH-1:0]   nonempty;
   logic [NCH-1:0]   push;
   logic [NCH-1:0]   pop;
   logic [CW-1:0]    grant;
   logic             fire;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         nonempty[i]           = (level_q[i] != '0);
         wr_ready[i]           = (level_q[i] < LW'(DEPTH));
         level[i*LW +: LW]     = level_q[i];
      end
   end

   // Round-robin search from the channel after the last one popped; a read
   // left pending overrides the search so rd_chan/rd_data cannot move.
   always_comb begin
      int  idx;
      logic found;
      idx   = 0;
      found = 1'b0;
      grant = '0;
      for (int k = 1; k <= NCH; k++) begin
         idx = (int'(last_grant_q) + k) % NCH;
         if (!found && nonempty[idx]) begin
            grant = CW'(idx);
            found = 1'b1;
         end
      end
      if (lock_q) grant = lock_chan_q;
   end

   assign rd_valid = |nonempty;
   assign rd_chan  = rd_valid ? grant : '0;
   assign rd_data  = rd_valid ? mem_q[grant][rd_ptr_q[grant]] : '0;
   assign fire     = rd_valid && rd_ready;
   assign drop_cnt = drop_cnt_q;

   always_comb begin
      int total;
      total = int'(drop_cnt_q);
      for (int i = 0; i < NCH; i++) begin
         push[i] = wr_valid[i] && wr_ready[i];
         pop[i]  = fire && (grant == CW'(i));
         if (wr_valid[i] && !wr_ready[i]) total = total + 1;
      end
      drop_cnt_d = (total > 255) ? 8'hFF : 8'(total);
   end

   // Storage carries no reset: stale entries are unreachable once levels clear.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= wr_data[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            level_q[i]  <= '0;
         end
         last_grant_q <= CW'(NCH - 1);
         lock_chan_q  <= '0;
         lock_q       <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
            if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
            case ({push[i], pop[i]})
               2'b10:   level_q[i] <= level_q[i] + LW'(1);
               2'b01:   level_q[i] <= level_q[i] - LW'(1);
               default: level_q[i] <= level_q[i];
            endcase
         end
         if (fire) begin
            lock_q       <= 1'b0;
            last_grant_q <= grant;
         end else if (rd_valid) begin
            lock_q      <= 1'b1;
            lock_chan_q <= grant;
         end
         drop_cnt_q <= drop_cnt_d;
      end
   end

endmodule

// File: tb/tb_mbox_arb.sv
// Directed bench for mbox_arb (WIDTH=8, NCH=4, DEPTH=4): vector table plus
// hand sequences for saturation and asynchronous reset.
module tb_mbox_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  wr_valid;
   logic [31:0] wr_data;
   logic [3:0]  wr_ready;
   logic        rd_valid;
   logic        rd_ready;
   logic [7:0]  rd_data;
   logic [1:0]  rd_chan;
   logic [11:0] level;
   logic [7:0]  drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   mbox_arb #(.WIDTH(8), .NCH(4), .DEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .rd_chan  (rd_chan),
      .level    (level),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  wv;
      logic [31:0] wd;
      logic        rr;
      logic        erv;
      logic [1:0]  ech;
      logic [7:0]  edat;
      logic [11:0] elev;
      logic [3:0]  ewr;
      logic [7:0]  edrop;
   } vec_t;

   vec_t vecs [21];

   function automatic vec_t mk(input logic [3:0] wv, input logic [31:0] wd, input logic rr,
                               input logic erv, input logic [1:0] ech, input logic [7:0] edat,
                               input logic [11:0] elev, input logic [3:0] ewr, input logic [7:0] edrop);
      vec_t v;
      v.wv = wv; v.wd = wd; v.rr = rr; v.erv = erv; v.ech = ech;
      v.edat = edat; v.elev = elev; v.ewr = ewr; v.edrop = edrop;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic erv, input logic [1:0] ech,
                             input logic [7:0] edat, input logic [11:0] elev,
                             input logic [3:0] ewr, input logic [7:0] edrop);
      check({tag, ".rd_valid"}, 32'(rd_valid), 32'(erv));
      check({tag, ".rd_chan"},  32'(rd_chan),  32'(ech));
      check({tag, ".rd_data"},  32'(rd_data),  32'(edat));
      check({tag, ".level"},    32'(level),    32'(elev));
      check({tag, ".wr_ready"}, 32'(wr_ready), 32'(ewr));
      check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(edrop));
   endtask

   task automatic step(input logic [3:0] wv, input logic [31:0] wd, input logic rr);
      @(negedge clk);
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // order 0,1,3 from reset; then single push/pop on channel 2
      vecs[0]  = mk(4'b1011, 32'h33002110, 1'b0, 1'b1, 2'd0, 8'h10, 12'h209, 4'hF, 8'd0);
      vecs[1]  = mk(4'b0000, 32'h0,        1'b1, 1'b1, 2'd1, 8'h21, 12'h208, 4'hF, 8'd0);
      vecs[2]  = mk(4'b0000, 32'h0,        1'b1, 1'b1, 2'd3, 8'h33, 12'h200, 4'hF, 8'd0);
      vecs[3]  = mk(4'b0000, 32'h0,        1'b1, 1'b0, 2'd0, 8'h00, 12'h000, 4'hF, 8'd0);
      vecs[4]  = mk(4'b0100, 32'h00AB0000, 1'b0, 1'b1, 2'd2, 8'hAB, 12'h040, 4'hF, 8'd0);
      vecs[5]  = mk(4'b0000, 32'h0,        1'b1, 1'b0, 2'd0, 8'h00, 12'h000, 4'hF, 8'd0);
      // grant lock: ch1 pending, ch0 arrives and would win the search
      vecs[6]  = mk(4'b0010, 32'h00005500, 1'b0, 1'b1, 2'd1, 8'h55, 12'h008, 4'hF, 8'd0);
      vecs[7]  = mk(4'b0001, 32'h00000066, 1'b0, 1'b1, 2'd1, 8'h55, 12'h009, 4'hF, 8'd0);
      vecs[8]  = mk(4'b0000, 32'h0,        1'b0, 1'b1, 2'd1, 8'h55, 12'h009, 4'hF, 8'd0);
      vecs[9]  = mk(4'b0000, 32'h0,        1'b1, 1'b1, 2'd0, 8'h66, 12'h001, 4'hF, 8'd0);
      vecs[10] = mk(4'b0000, 32'h0,        1'b1, 1'b0, 2'd0, 8'h00, 12'h000, 4'hF, 8'd0);
      // fill ch0, overflow, full+pop same cycle, push+pop across wrap
      vecs[11] = mk(4'b0001, 32'h000000A0, 1'b0, 1'b1, 2'd0, 8'hA0, 12'h001, 4'hF, 8'd0);
      vecs[12] = mk(4'b0001, 32'h000000A1, 1'b0, 1'b1, 2'd0, 8'hA0, 12'h002, 4'hF, 8'd0);
      vecs[13] = mk(4'b0001, 32'h000000A2, 1'b0, 1'b1, 2'd0, 8'hA0, 12'h003, 4'hF, 8'd0);
      vecs[14] = mk(4'b0001, 32'h000000A3, 1'b0, 1'b1, 2'd0, 8'hA0, 12'h004, 4'hE, 8'd0);
      vecs[15] = mk(4'b0001, 32'h000000FF, 1'b0, 1'b1, 2'd0, 8'hA0, 12'h004, 4'hE, 8'd1);
      vecs[16] = mk(4'b0001, 32'h000000EE, 1'b1, 1'b1, 2'd0, 8'hA1, 12'h003, 4'hF, 8'd2);
      vecs[17] = mk(4'b0000, 32'h0,        1'b1, 1'b1, 2'd0, 8'hA2, 12'h002, 4'hF, 8'd2);
      vecs[18] = mk(4'b0001, 32'h00000011, 1'b1, 1'b1, 2'd0, 8'hA3, 12'h002, 4'hF, 8'd2);
      vecs[19] = mk(4'b0000, 32'h0,        1'b1, 1'b1, 2'd0, 8'h11, 12'h001, 4'hF, 8'd2);
      vecs[20] = mk(4'b0000, 32'h0,        1'b1, 1'b0, 2'd0, 8'h00, 12'h000, 4'hF, 8'd2);

      rst_n    = 1'b0;
      wr_valid = '0;
      wr_data  = '0;
      rd_ready = 1'b0;
      #12;
      check_outs("reset", 1'b0, 2'd0, 8'h00, 12'h000, 4'hF, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 21; i++) begin
         step(vecs[i].wv, vecs[i].wd, vecs[i].rr);
         check_outs($sformatf("v%0d", i), vecs[i].erv, vecs[i].ech, vecs[i].edat,
                    vecs[i].elev, vecs[i].ewr, vecs[i].edrop);
      end

      // All four channels full, then every channel rejects each cycle
      for (int i = 0; i < 4; i++) step(4'hF, 32'hC3C2C1C0, 1'b0);
      check_outs("fill_all", 1'b1, 2'd1, 8'hC1, 12'h924, 4'h0, 8'd2);
      step(4'hF, 32'hC3C2C1C0, 1'b0);
      check("drop_multi", 32'(drop_cnt), 32'd6);
      for (int i = 0; i < 75; i++) step(4'hF, 32'hC3C2C1C0, 1'b0);
      check("drop_sat", 32'(drop_cnt), 32'd255);
      check("sat_level", 32'(level), 32'h924);
      step(4'hF, 32'hC3C2C1C0, 1'b0);
      check("drop_hold", 32'(drop_cnt), 32'd255);

      @(negedge clk);
      wr_valid = '0;
      rst_n    = 1'b0;
      #1;
      check_outs("rst_full", 1'b0, 2'd0, 8'h00, 12'h000, 4'hF, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      step(4'b0111, 32'h00030201, 1'b0);
      check_outs("three_ch", 1'b1, 2'd0, 8'h01, 12'h049, 4'hF, 8'd0);
      @(negedge clk);
      wr_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("rst_mid", 1'b0, 2'd0, 8'h00, 12'h000, 4'hF, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      step(4'b1000, 32'h77000000, 1'b0);
      check_outs("post_rst", 1'b1, 2'd3, 8'h77, 12'h200, 4'hF, 8'd0);
      step(4'b0000, 32'h0, 1'b1);
      check_outs("post_pop", 1'b0, 2'd0, 8'h00, 12'h000, 4'hF, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
